// File: rtl/lcd_write_arbiter.sv
// Two-requester round-robin arbiter in front of a single LCD write controller.
// Each accepted write is held on lcd_* until done or timeout, then followed by a fixed settle gap.
module lcd_write_arbiter #(
    parameter int unsigned SETTLE_CYC = 18'h3FFFE,
    parameter int unsigned TMO_CYC    = 20'hFFFFF
) (
    input  logic       clk_i,
    input  logic       rst_i,

    input  logic       req0_valid_i,
    input  logic       req0_rs_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_lock_i,
    output logic       req0_ready_o,

    input  logic       req1_valid_i,
    input  logic       req1_rs_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_lock_i,
    output logic       req1_ready_o,

    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_start_o,
    input  logic       lcd_done_i,

    output logic       busy_o,
    output logic       grant_o,
    output logic       err_o
);

    localparam int unsigned TmoW    = (TMO_CYC    > 1) ? $clog2(TMO_CYC + 1)    : 1;
    localparam int unsigned SettleW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StSettle
    } state_e;

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic               grant_q, grant_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;
    logic               rs_q, rs_d;
    logic               ready0_q, ready0_d;
    logic               ready1_q, ready1_d;
    logic [TmoW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [SettleW-1:0] settle_cnt_q, settle_cnt_d;

    logic any_valid;
    logic win1;
    logic grant_lock;

    assign any_valid  = req0_valid_i | req1_valid_i;
    // Requester 1 wins when it is the only one asking, or on a tie when prio points at it.
    assign win1       = req1_valid_i & (~req0_valid_i | prio_q);
    assign grant_lock = grant_q ? req1_lock_i : req0_lock_i;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        grant_d      = grant_q;
        err_d        = err_q;
        start_d      = start_q;
        data_d       = data_q;
        rs_d         = rs_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
        settle_cnt_d = settle_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d   = StIssue;
                    grant_d   = win1;
                    data_d    = win1 ? req1_data_i : req0_data_i;
                    rs_d      = win1 ? req1_rs_i : req0_rs_i;
                    start_d   = 1'b1;
                    ready0_d  = ~win1;
                    ready1_d  = win1;
                    tmo_cnt_d = '0;
                end
            end
            StIssue: begin
                if (lcd_done_i) begin
                    state_d      = StSettle;
                    start_d      = 1'b0;
                    settle_cnt_d = '0;
                end else if (tmo_cnt_q == TmoW'(TMO_CYC - 1)) begin
                    // Abandon the write; the requester already saw ready, so nothing retries it.
                    state_d      = StSettle;
                    start_d      = 1'b0;
                    err_d        = 1'b1;
                    settle_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StSettle: begin
                if (settle_cnt_q == SettleW'(SETTLE_CYC - 1)) begin
                    state_d = StIdle;
                    prio_d  = grant_lock ? grant_q : ~grant_q;
                end else begin
                    settle_cnt_d = settle_cnt_q + SettleW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            prio_q       <= 1'b0;
            grant_q      <= 1'b0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            data_q       <= 8'h00;
            rs_q         <= 1'b0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            grant_q      <= grant_d;
            err_q        <= err_d;
            start_q      <= start_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            tmo_cnt_q    <= tmo_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign req0_ready_o = ready0_q;
    assign req1_ready_o = ready1_q;
    assign lcd_data_o   = data_q;
    assign lcd_rs_o     = rs_q;
    assign lcd_start_o  = start_q;
    assign busy_o       = (state_q != StIdle);
    assign grant_o      = grant_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized bench for lcd_write_arbiter against a timestamp-based transaction model.
module tb_lcd_write_arbiter;

    localparam int unsigned SettleCyc = 4;
    localparam int unsigned TmoCyc    = 16;
    localparam int          NumCyc    = 3000;
    localparam int          Never     = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst;
    logic       v0, rs0, l0, v1, rs1, l1;
    logic [7:0] d0, d1;
    logic       done;
    logic       rdy0, rdy1, start, rs, busy, grant, err;
    logic [7:0] data;

    always #5 clk = ~clk;

    lcd_write_arbiter #(
        .SETTLE_CYC (SettleCyc),
        .TMO_CYC    (TmoCyc)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (v0),
        .req0_rs_i    (rs0),
        .req0_data_i  (d0),
        .req0_lock_i  (l0),
        .req0_ready_o (rdy0),
        .req1_valid_i (v1),
        .req1_rs_i    (rs1),
        .req1_data_i  (d1),
        .req1_lock_i  (l1),
        .req1_ready_o (rdy1),
        .lcd_data_o   (data),
        .lcd_rs_o     (rs),
        .lcd_start_o  (start),
        .lcd_done_i   (done),
        .busy_o       (busy),
        .grant_o      (grant),
        .err_o        (err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Model: expected outputs for the next cycle, plus write timeline as cycle timestamps.
    logic [1:0] e_ready;
    logic       e_start, e_grant, e_rs, e_err, e_busy, m_prio, m_in_issue;
    logic [7:0] e_data;
    int         m_issue_begin;
    int         m_free;      // first cycle in which a new request can be sampled

    task automatic model_step(input int c);
        logic w;
        e_ready = 2'b00;
        if (rst) begin
            e_start = 0; e_grant = 0; e_rs = 0; e_err = 0; e_data = 8'h00;
            m_prio = 0; m_in_issue = 0; m_free = c + 1;
        end else if (c >= m_free) begin
            if (v0 || v1) begin
                w = (v0 && v1) ? m_prio : v1;
                e_ready       = w ? 2'b10 : 2'b01;
                e_grant       = w;
                e_data        = w ? d1 : d0;
                e_rs          = w ? rs1 : rs0;
                e_start       = 1;
                m_in_issue    = 1;
                m_issue_begin = c + 1;
                m_free        = Never;
            end
        end else if (m_in_issue) begin
            if (done || (c - m_issue_begin == int'(TmoCyc) - 1)) begin
                if (!done) e_err = 1;
                e_start    = 0;
                m_in_issue = 0;
                m_free     = c + 1 + int'(SettleCyc);
            end
        end else if (c == m_free - 1) begin
            m_prio = (e_grant ? l1 : l0) ? e_grant : !e_grant;
        end
        e_busy = !(c + 1 >= m_free);
    endtask

    int resp_cnt = 0;
    int resp_lat = 3;
    int phase;

    initial begin
        rst = 1; v0 = 0; rs0 = 0; d0 = 0; l0 = 0; v1 = 0; rs1 = 0; d1 = 0; l1 = 0; done = 0;
        model_step(0);
        for (int i = 1; i < NumCyc; i++) begin
            @(negedge clk);
            cyc = i;
            check_eq("req0_ready", 32'(rdy0), 32'(e_ready[0]));
            check_eq("req1_ready", 32'(rdy1), 32'(e_ready[1]));
            check_eq("lcd_start", 32'(start), 32'(e_start));
            check_eq("grant", 32'(grant), 32'(e_grant));
            check_eq("lcd_data", 32'(data), 32'(e_data));
            check_eq("lcd_rs", 32'(rs), 32'(e_rs));
            check_eq("busy", 32'(busy), 32'(e_busy));
            check_eq("err", 32'(err), 32'(e_err));

            phase = (i < 80) ? 0 : (i < 250) ? 1 : (i < 420) ? 2 : (i < 520) ? 3 :
                    (i < 640) ? 4 : 5;
            rst = (i < 2) ? 1'b1 : (phase == 5) ? ($urandom_range(0, 99) == 0) : 1'b0;

            unique case (phase)
                0, 4: begin
                    v0 = 1; rs0 = 1; d0 = 8'h41; l0 = 0; v1 = 0; l1 = 0;
                end
                1, 2, 3: begin
                    v0 = 1; rs0 = 0; d0 = 8'h20; l0 = 0;
                    v1 = 1; rs1 = 1; d1 = 8'hC0; l1 = (phase == 2);
                end
                default: begin
                    if (!v0) begin
                        if ($urandom_range(0, 2) == 0) begin
                            v0 = 1; d0 = 8'($urandom); rs0 = 1'($urandom);
                        end
                    end else if (rdy0) begin
                        if ($urandom_range(0, 1) == 0) v0 = 0;
                        else begin d0 = 8'($urandom); rs0 = 1'($urandom); end
                    end
                    if (!v1) begin
                        if ($urandom_range(0, 2) == 0) begin
                            v1 = 1; d1 = 8'($urandom); rs1 = 1'($urandom);
                        end
                    end else if (rdy1) begin
                        if ($urandom_range(0, 1) == 0) v1 = 0;
                        else begin d1 = 8'($urandom); rs1 = 1'($urandom); end
                    end
                    if ($urandom_range(0, 7) == 0) l0 = 1'($urandom);
                    if ($urandom_range(0, 7) == 0) l1 = 1'($urandom);
                end
            endcase

            // LCD controller: done after resp_lat start cycles; 0 or >TmoCyc means it never comes.
            if (start) begin
                resp_cnt++;
                done = (resp_lat != 0) && (resp_cnt == resp_lat);
            end else begin
                resp_cnt = 0;
                resp_lat = (phase == 4) ? 0 : (phase == 5) ? $urandom_range(0, 20) : 3;
                done = (phase == 5) && ($urandom_range(0, 9) == 0);
            end

            model_step(i);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
